// File: rtl/tlk_link_err_monitor.sv
// tlk_link_err_monitor: per-lane TLK2711 receive word classifier, lock FSM and windowed error reporter
module tlk_link_err_monitor #(
  parameter int LOCK_WORDS = 16,
  parameter int WINDOW     = 1024,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      rx_data,
  input  logic             rx_klsb,
  input  logic             rx_kmsb,
  output logic             err_flag,
  output logic             send_err,
  output logic [1:0]       link_state,
  output logic [CNT_W-1:0] err_count
);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  typedef enum logic [1:0] {DOWN = 2'b00, ACQ = 2'b01, UP = 2'b10} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [15:0] good_q, good_d;
  logic [EW-1:0] werr_q, werr_d;
  logic flag_q, flag_d, send_q, send_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_idle, is_err, at_end;
  assign is_idle = rx_klsb & ~rx_kmsb & (rx_data == 16'hC5BC);
  assign is_err  = ~(is_idle | (~rx_klsb & ~rx_kmsb));
  assign at_end  = win_q == WW'(WINDOW - 1);
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    werr_d  = werr_q;
    win_d   = win_q;
    flag_d  = flag_q;
    send_d  = 1'b0;
    cnt_d   = cnt_q;
    if (enable) begin
      cnt_d = (is_err && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      case (state_q)
        DOWN: if (is_idle) begin
          state_d = ACQ;
          good_d  = 16'd1;
        end
        ACQ: if (is_err) begin
          state_d = DOWN;
          good_d  = '0;
        end else begin
          good_d  = good_q + 16'd1;
          state_d = (good_d == 16'(LOCK_WORDS)) ? UP : ACQ;
        end
        UP: if (is_err) begin
          werr_d  = (werr_q == EW'(ERR_THRESH)) ? werr_q : werr_q + 1'b1;
          state_d = (werr_q >= EW'(ERR_THRESH - 1)) ? DOWN : UP;
        end
        default: state_d = DOWN;
      endcase
      win_d = at_end ? '0 : win_q + 1'b1;
      // the boundary report sees this edge's state change and error before win_errs clears
      if (at_end) begin
        send_d = 1'b1;
        flag_d = (state_d != UP) || (werr_d != '0);
        werr_d = '0;
      end
    end else begin
      state_d = DOWN;
      good_d  = '0;
      werr_d  = '0;
      win_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DOWN;
      win_q   <= '0;
      good_q  <= '0;
      werr_q  <= '0;
      flag_q  <= 1'b1;
      send_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      good_q  <= good_d;
      werr_q  <= werr_d;
      flag_q  <= flag_d;
      send_q  <= send_d;
      cnt_q   <= cnt_d;
    end
  end
  assign err_flag   = flag_q;
  assign send_err   = send_q;
  assign link_state = state_q;
  assign err_count  = cnt_q;
endmodule

// File: tb/tb_tlk_link_err_monitor.sv
// tb_tlk_link_err_monitor: randomized scoreboard bench for the link error monitor
module tb_tlk_link_err_monitor;
  localparam int LOCK_WORDS = 16;
  localparam int WINDOW     = 1024;
  localparam int ERR_THRESH = 4;
  localparam int CNT_MAX    = 65535;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [15:0] rx_data = 16'h0;
  logic rx_klsb = 1'b0;
  logic rx_kmsb = 1'b0;
  logic err_flag, send_err;
  logic [1:0] link_state;
  logic [15:0] err_count;
  typedef struct packed {
    logic send;
    logic flag;
    logic [1:0] st;
    logic [15:0] cnt;
  } rec_t;
  rec_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  // reference: lock level (0 down, 1 acquiring, 2 locked), consecutive good run,
  // errors seen while locked in this window, position in window, reported status
  int m_lvl = 0, m_run = 0, m_we = 0, m_pos = 0, m_cnt = 0;
  bit m_flag = 1'b1, m_send = 1'b0;
  tlk_link_err_monitor #(.LOCK_WORDS(LOCK_WORDS), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_data(rx_data), .rx_klsb(rx_klsb),
    .rx_kmsb(rx_kmsb), .err_flag(err_flag), .send_err(send_err), .link_state(link_state),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  // kind: 0 IDLE, 1 DATA, 2 ERR, 3 BAD
  task automatic step(input logic rst, input logic en, input int kind);
    logic [15:0] d;
    bit err;
    @(negedge clk);
    reset = rst;
    enable = en;
    d = 16'($urandom);
    case (kind)
      0: begin rx_data = 16'hC5BC; rx_klsb = 1'b1; rx_kmsb = 1'b0; end
      1: begin rx_data = d; rx_klsb = 1'b0; rx_kmsb = 1'b0; end
      2: begin rx_data = d; rx_klsb = 1'b1; rx_kmsb = 1'b1; end
      default: begin
        if ($urandom_range(1) == 0) begin
          rx_data = d; rx_klsb = 1'b0; rx_kmsb = 1'b1;
        end else begin
          rx_data = (d == 16'hC5BC) ? 16'hC5BD : d; rx_klsb = 1'b1; rx_kmsb = 1'b0;
        end
      end
    endcase
    err = kind >= 2;
    if (rst) begin
      m_lvl = 0; m_run = 0; m_we = 0; m_pos = 0; m_cnt = 0; m_flag = 1'b1; m_send = 1'b0;
    end else if (!en) begin
      m_lvl = 0; m_run = 0; m_we = 0; m_pos = 0; m_send = 1'b0;
    end else begin
      if (err && m_cnt < CNT_MAX) m_cnt++;
      if (m_lvl == 0) begin
        if (kind == 0) begin m_lvl = 1; m_run = 1; end
      end else if (m_lvl == 1) begin
        if (err) begin m_lvl = 0; m_run = 0; end
        else begin m_run++; if (m_run == LOCK_WORDS) m_lvl = 2; end
      end else if (err) begin
        m_we = (m_we + 1 > ERR_THRESH) ? ERR_THRESH : m_we + 1;
        if (m_we >= ERR_THRESH) m_lvl = 0;
      end
      m_send = (m_pos == WINDOW - 1);
      if (m_send) begin
        m_flag = (m_lvl != 2) || (m_we > 0);
        m_we = 0;
        m_pos = 0;
      end else m_pos++;
    end
    exp_q.push_back('{send: m_send, flag: m_flag, st: 2'(m_lvl), cnt: 16'(m_cnt)});
  endtask
  function automatic int good_kind();
    return int'($urandom_range(1));
  endfunction
  initial begin
    rec_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{send: send_err, flag: err_flag, st: link_state, cnt: err_count};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: got send=%b flag=%b state=%b cnt=%0d, expected send=%b flag=%b state=%b cnt=%0d",
                   cyc, g.send, g.flag, g.st, g.cnt, e.send, e.flag, e.st, e.cnt);
        end
      end
    end
  end
  initial begin
    repeat (3) step(1'b1, 1'b0, 0);
    repeat (1100) step(1'b0, 1'b1, 0);
    for (int i = 0; i < 2048; i++)
      step(1'b0, 1'b1, (i == 100 || i == 300 || i == 500) ? 2 : good_kind());
    for (int i = 0; i < 1500; i++)
      step(1'b0, 1'b1, (i >= 10 && i < 14) ? 2 : (i < 100 ? 0 : good_kind()));
    repeat (4) step(1'b0, 1'b1, 2);
    step(1'b0, 1'b1, 0);
    repeat (9) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 0);
    repeat (15) step(1'b0, 1'b1, 1);
    repeat (1100) step(1'b0, 1'b1, good_kind());
    while (m_pos != WINDOW - 1) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 2);
    repeat (2100) step(1'b0, 1'b1, good_kind());
    for (int i = 0; i < 3000; i++) begin
      int r, k;
      r = int'($urandom_range(99));
      k = (r < 2) ? 2 + int'($urandom_range(1)) : good_kind();
      if (i < 300 && r < 20) k = 0;
      step(i >= 2000 && i < 2002, !(i >= 1000 && i < 1050), k);
    end
    repeat (40) step(1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 2);
    repeat (3) step(1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tlk_link_err_monitor.md
Name: tlk_link_err_monitor

Overview:
- Per-channel receive-side link monitor for one TLK2711 SERDES lane.
- Classifies each received 16-bit word, tracks link lock with a small FSM, and accumulates errors over a fixed reporting window.
- At each window boundary it issues a one-cycle send_err strobe together with a stable err_flag. These are the source of the err_in_NN / send_err_NN pair consumed by the layer-2 error output latch.
- One instance per lane; three instances feed the three latch channels.

Parameters:
- LOCK_WORDS, 16: consecutive good words required in ACQ before declaring link UP (2..65535).
- WINDOW, 1024: reporting window length in clk cycles (>=4).
- ERR_THRESH, 4: errors within one window, while UP, that force the link DOWN (>=1).
- CNT_W, 16: width of the cumulative error counter.

Ports:
- clk  in  1  receive word clock (TLK RX_CLK domain).
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- enable  in  1  monitor enable; 0 holds block idle.
- rx_data  in  16  TLK receive data word.
- rx_klsb  in  1  TLK RKLSB.
- rx_kmsb  in  1  TLK RKMSB.
- err_flag  out  1  window error status; to err_in_NN.
- send_err  out  1  one-cycle report strobe; to send_err_NN.
- link_state  out  2  00 DOWN, 01 ACQ, 10 UP.
- err_count  out  CNT_W  cumulative saturating error count.

Behaviour:
- Word classes are evaluated combinationally on the sampled inputs:
  - IDLE: klsb=1, kmsb=0, rx_data=16'hC5BC.
  - DATA: klsb=0, kmsb=0 (any data).
  - ERR: klsb=1, kmsb=1.
  - BAD: anything else. BAD counts as an error.
  - good = IDLE or DATA.
- All outputs are registered. Input word at edge t affects state and counters at edge t (visible in the cycle after t).
- Reset values: link_state=DOWN, err_flag=1, send_err=0, err_count=0. Window counter and consecutive-good counter are 0.
- Reset mid-operation overrides everything in the same edge, including a pending send_err.
- FSM:
  - DOWN: IDLE word -> ACQ, with the good counter set to 1. Any other word stays in DOWN.
  - ACQ:
    - Error word -> DOWN, good counter cleared.
    - Good word increments the good counter.
    - When the increment reaches LOCK_WORDS -> UP.
  - UP:
    - Error word increments win_errs (saturating at ERR_THRESH).
    - If win_errs+1 >= ERR_THRESH on that edge -> DOWN.
- err_count increments by 1 on every error word while enable=1, in any state, and saturates at all-ones. It is cleared only by reset.
- Window counter runs 0..WINDOW-1 and wraps whenever enable=1, independent of link state.
- At the edge where the window counter equals WINDOW-1:
  - send_err=1 for exactly that next cycle.
  - err_flag := 1 if the (post-update) state != UP, or if win_errs (including an error on this same edge) > 0; else 0.
  - win_errs cleared to 0. An error on the boundary edge is reported in the closing window, not carried over.
- err_flag holds its value between strobes.
- enable=0:
  - state forced DOWN; window, good and win_errs counters cleared.
  - send_err=0; err_flag and err_count held.
  - On re-enable, the window restarts at 0.
- A DOWN transition caused by threshold and a window boundary on the same edge: the report sees state DOWN, so err_flag=1.

Test Plan:
1. Reset, enable=1, drive IDLE (C5BC, klsb=1) continuously -> link_state 01 after 1 word, 10 after 16 words. First send_err at cycle 1024 after reset release with err_flag=0. err_count=0.
2. While UP, inject 3 ERR words in one window -> remains UP. Next strobe has err_flag=1, err_count=3. The following clean window strobes err_flag=0.
3. While UP, inject 4 ERR words in one window -> link_state=00 on the 4th error's edge. Re-lock takes 1+15 good words. Strobe err_flag=1.
4. In ACQ after 10 good words, inject one BAD word (klsb=0, kmsb=1) -> DOWN. Lock needs a fresh IDLE plus 16 total good words.
5. Single ERR word exactly on window-boundary edge while UP -> that strobe has err_flag=1. Next window win_errs starts at 0 and strobes err_flag=0.
6. Deassert enable mid-window for 50 cycles, then assert reset mid-window -> no strobe while disabled, err_count held. Reset clears all to reset values, and err_flag reads 1.
